// File: rtl/add_seq_pkg.sv
// ----------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the byte-serial add/sub sequencer:
//   state_t  - sequencer FSM states (IDLE, RUN, DONE)
//   BYTE_W   - width of the shared adder slice (one byte per cycle)
// ----------------------------------------------------------------------------
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : add_seq_pkg

// File: rtl/cla8_cin.sv
// ----------------------------------------------------------------------------
// cla8_cin
// 8-bit carry-lookahead adder with carry-in. Per-bit cells produce
// generate/propagate terms; every carry is then formed directly from those
// terms and cin, so no carry ripples through a previous sum bit.
//
// Ports:
//   a, b  [7:0]  addends
//   cin          carry-in
//   s     [7:0]  sum
//   cout         carry-out of bit 7
// ----------------------------------------------------------------------------
module cla8_cin
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  for (genvar i = 0; i < BYTE_W; i++) begin : gp_cell
    assign g[i] = a[i] & b[i];
    assign p[i] = a[i] ^ b[i];
  end

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin,
  // expanded as a flat sum of products for each bit position.
  always_comb begin : lookahead
    logic acc;
    logic prop;
    // NOTE: every variable written here gets a value on every pass before it
    // is read, so no latch can be inferred.
    acc  = 1'b0;
    prop = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = acc | (prop & cin);
    end
  end

  assign s    = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule : cla8_cin

// File: rtl/add_sequencer.sv
// ----------------------------------------------------------------------------
// add_sequencer
// Byte-serial adder/subtractor. An accepted operation is processed one byte
// per cycle, LSB first, through a single shared 8-bit CLA; the result is then
// held until the consumer takes it.
//
// Parameters:
//   NBYTES     operand width in bytes (legal range 2..16)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   op_a/op_b/sub are valid
//   in_ready   ready to accept (high only in IDLE)
//   op_a       operand A, 8*NBYTES bits
//   op_b       operand B, 8*NBYTES bits
//   sub        0: A+B, 1: A-B
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        result modulo 2^(8*NBYTES)
//   cout       final carry (for subtract, 1 = no borrow)
//   ovf        two's-complement signed overflow
// ----------------------------------------------------------------------------
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_t state_q;
  state_t state_d;

  logic [NBYTES-1:0][BYTE_W-1:0] a_q;
  logic [NBYTES-1:0][BYTE_W-1:0] b_q;
  logic                          sub_q;
  logic [NBYTES-1:0][BYTE_W-1:0] sum_q;
  logic [IDXW-1:0]               idx_q;
  logic                          carry_q;
  logic                          cout_q;
  logic                          ovf_q;

  logic              accept;
  logic              last_byte;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_eff;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last_byte = (idx_q == LAST_IDX);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples the same pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_byte) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte mux and shared adder. Subtraction is A + ~B + 1: B is inverted here
  // and the +1 comes from the carry register being loaded with sub on accept.
  // --------------------------------------------------------------------------
  assign a_byte = a_q[idx_q];
  assign b_eff  = b_q[idx_q] ^ {BYTE_W{sub_q}};

  cla8_cin u_cla (
    .a    (a_byte),
    .b    (b_eff),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // --------------------------------------------------------------------------
  // Operand capture
  // --------------------------------------------------------------------------
  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before the datapath ever reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      sub_q <= sub;
    end
  end

  // --------------------------------------------------------------------------
  // Byte index, carry chain and result registers. Outside RUN the result
  // registers simply hold, which keeps them stable throughout DONE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= sub;
    end else if (state_q == RUN) begin
      sum_q[idx_q] <= add_s;
      carry_q      <= add_co;
      if (last_byte) begin
        // Signed overflow: operands agree in sign but the result does not.
        cout_q <= add_co;
        ovf_q  <= (a_byte[BYTE_W-1] == b_eff[BYTE_W-1]) &
                  (add_s[BYTE_W-1] != a_byte[BYTE_W-1]);
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : add_sequencer

// File: tb/tb_add_sequencer.sv
// ----------------------------------------------------------------------------
// tb_add_sequencer
// Self-checking bench for add_sequencer with NBYTES=4. Expected results come
// from a plain-arithmetic reference model; directed corner cases are followed
// by randomized operations, a result stall, a mid-run reset and a
// back-to-back throughput run.
// ----------------------------------------------------------------------------
module tb_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  add_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned arithmetic for sum/carry, signed arithmetic range
  // test for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
    res_t            r;
    longint unsigned ua, ub, uw;
    longint          sa, sb, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      uw     = ua + ub;
      r.cout = (uw > 64'h0000_0000_FFFF_FFFF);
      sr     = sa + sb;
    end else begin
      uw     = ua - ub;
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end
    r.sum = uw[W-1:0];
    r.ovf = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    check("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // One complete operation: accept, scribble on the inputs while it runs,
  // check latency and result, optionally stall in DONE, then release.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input int hold);
    res_t exp;
    int   lat;
    exp = model(a, b, s);
    wait_ready();
    op_a      = a;
    op_b      = b;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a     = $urandom;
      op_b     = $urandom;
      sub      = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(NB));
    check({tag, "_sum"},  64'(sum),  64'(exp.sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp.cout));
    check({tag, "_ovf"},  64'(ovf),  64'(exp.ovf));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      op_a     = $urandom;
      op_b     = $urandom;
      sub      = ~sub;
      step();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready),  64'd0);
      check({tag, "_hold_sum"},   64'(sum),       64'(exp.sum));
      check({tag, "_hold_flags"}, {62'd0, cout, ovf}, {62'd0, exp.cout, exp.ovf});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_release_ready"}, 64'(in_ready),  64'd1);
    // Result registers must still show this operation, not a second one.
    check({tag, "_release_sum"},   64'(sum),       64'(exp.sum));
  endtask

  initial begin
    res_t  q[$];
    res_t  exp;
    int    accepts;
    int    last_acc;
    int    outs;
    bit    seen_valid;
    logic [W-1:0] ra, rb;
    logic         rs;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum",       64'(sum),       64'd0);
    check("reset_flags",     {62'd0, cout, ovf}, 64'd0);

    // Directed corner cases.
    run_op("carry_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op("wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 0);

    // Stall in DONE for 3 cycles with inputs toggling.
    run_op("stall", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 3);

    // Randomized operations.
    for (int n = 0; n < 30; n++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    // Reset while RUN is processing byte 2.
    wait_ready();
    op_a     = 32'h1122_3344;
    op_b     = 32'h5566_7788;
    sub      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum",       64'(sum),       64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    seen_valid = 1'b0;
    for (int k = 0; k < NB + 2; k++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_result", 64'(seen_valid), 64'd0);
    run_op("after_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 0);

    // Back-to-back with out_ready tied high.
    accepts   = 0;
    outs      = 0;
    last_acc  = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 200 && (accepts < 6 || q.size() != 0); cyc++) begin
      if (out_valid) begin
        if (q.size() > 0) begin
          exp = q.pop_front();
          check("b2b_sum",   64'(sum), 64'(exp.sum));
          check("b2b_flags", {62'd0, cout, ovf}, {62'd0, exp.cout, exp.ovf});
        end else begin
          check("b2b_spurious_out", 64'd1, 64'd0);
        end
        outs++;
      end
      if (in_ready && accepts < 6) begin
        if (last_acc >= 0) check("b2b_interval", 64'(cyc - last_acc), 64'(NB + 2));
        last_acc = cyc;
        accepts++;
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        op_a     = ra;
        op_b     = rb;
        sub      = rs;
        in_valid = 1'b1;
        q.push_back(model(ra, rb, rs));
      end else begin
        in_valid = (accepts < 6);
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = 1'($urandom_range(0, 1));
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 64'(accepts), 64'd6);
    check("b2b_outputs", 64'(outs),    64'd6);
    check("b2b_drain",   64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add_sequencer
